// File: rtl/ctrl_seq_pkg.sv
// Shared types and constants for the hardwired control sequencer: state encoding,
// opcode map, ALU codes and IR field positions.
package ctrl_seq_pkg;

  localparam int unsigned WORD_W     = 32;
  localparam int unsigned REG_SEL_W  = 4;
  localparam int unsigned ALU_CTRL_W = 4;
  localparam int unsigned OPCODE_W   = 5;

  localparam int unsigned IrOpMsb = 31;
  localparam int unsigned IrOpLsb = 27;
  localparam int unsigned IrRaMsb = 26;
  localparam int unsigned IrRaLsb = 23;
  localparam int unsigned IrRbMsb = 22;
  localparam int unsigned IrRbLsb = 19;
  localparam int unsigned IrRcMsb = 18;
  localparam int unsigned IrRcLsb = 15;

  typedef enum logic [3:0] {
    StIdle, StT0, StT1, StMemw, StT2, StDec, StT3, StT4, StT5, StT6, StHalt
  } state_e;

  localparam logic [OPCODE_W-1:0] OpAnd  = 5'b00001;
  localparam logic [OPCODE_W-1:0] OpOr   = 5'b00010;
  localparam logic [OPCODE_W-1:0] OpShl  = 5'b00100;
  localparam logic [OPCODE_W-1:0] OpShr  = 5'b00101;
  localparam logic [OPCODE_W-1:0] OpRor  = 5'b00110;
  localparam logic [OPCODE_W-1:0] OpRol  = 5'b00111;
  localparam logic [OPCODE_W-1:0] OpAdd  = 5'b01000;
  localparam logic [OPCODE_W-1:0] OpSub  = 5'b01001;
  localparam logic [OPCODE_W-1:0] OpMul  = 5'b01010;
  localparam logic [OPCODE_W-1:0] OpDiv  = 5'b01011;
  localparam logic [OPCODE_W-1:0] OpNeg  = 5'b01100;
  localparam logic [OPCODE_W-1:0] OpNot  = 5'b01101;
  localparam logic [OPCODE_W-1:0] OpHalt = 5'b11111;

  localparam logic [ALU_CTRL_W-1:0] AluAnd = 4'h1;
  localparam logic [ALU_CTRL_W-1:0] AluOr  = 4'h2;
  localparam logic [ALU_CTRL_W-1:0] AluShl = 4'h4;
  localparam logic [ALU_CTRL_W-1:0] AluShr = 4'h5;
  localparam logic [ALU_CTRL_W-1:0] AluRor = 4'h6;
  localparam logic [ALU_CTRL_W-1:0] AluRol = 4'h7;
  localparam logic [ALU_CTRL_W-1:0] AluAdd = 4'h8;
  localparam logic [ALU_CTRL_W-1:0] AluSub = 4'h9;
  localparam logic [ALU_CTRL_W-1:0] AluMul = 4'hA;
  localparam logic [ALU_CTRL_W-1:0] AluDiv = 4'hB;
  localparam logic [ALU_CTRL_W-1:0] AluNeg = 4'hC;
  localparam logic [ALU_CTRL_W-1:0] AluNot = 4'hD;

  // The ALU code is the low nibble of the opcode by construction of the opcode map.
  function automatic logic [ALU_CTRL_W-1:0] alu_code(logic [OPCODE_W-1:0] op);
    return op[ALU_CTRL_W-1:0];
  endfunction

endpackage

// File: rtl/ctrl_seq_if.sv
// Control bundle between the sequencer (master) and the datapath (slave).
interface ctrl_seq_if;
  import ctrl_seq_pkg::*;

  logic                  run;
  logic [WORD_W-1:0]     ir;
  logic                  mem_ready;

  logic                  pc_out, zlow_out, zhigh_out, mdr_out;
  logic                  reg_out_en;
  logic [REG_SEL_W-1:0]  reg_out_sel;
  logic                  pc_in, mar_in, mdr_in, ir_in, y_in, z_in, hi_in, lo_in;
  logic                  reg_in_en;
  logic [REG_SEL_W-1:0]  reg_in_sel;
  logic                  inc_pc;
  logic                  mem_read;
  logic [ALU_CTRL_W-1:0] alu_ctrl;
  logic                  instr_done;
  logic                  illegal_op;
  logic                  halted;

  modport master (
    input  run, ir, mem_ready,
    output pc_out, zlow_out, zhigh_out, mdr_out, reg_out_en, reg_out_sel,
           pc_in, mar_in, mdr_in, ir_in, y_in, z_in, hi_in, lo_in, reg_in_en, reg_in_sel,
           inc_pc, mem_read, alu_ctrl, instr_done, illegal_op, halted
  );

  modport slave (
    output run, ir, mem_ready,
    input  pc_out, zlow_out, zhigh_out, mdr_out, reg_out_en, reg_out_sel,
           pc_in, mar_in, mdr_in, ir_in, y_in, z_in, hi_in, lo_in, reg_in_en, reg_in_sel,
           inc_pc, mem_read, alu_ctrl, instr_done, illegal_op, halted
  );

endinterface

// File: rtl/instr_decode.sv
// Opcode classifier: splits the opcode space into binary ALU, unary, MUL/DIV, HALT, illegal.
module instr_decode
  import ctrl_seq_pkg::*;
(
  input  logic [OPCODE_W-1:0] opcode,
  output logic                is_binary,
  output logic                is_unary,
  output logic                is_muldiv,
  output logic                is_halt,
  output logic                is_illegal
);

  always_comb begin
    is_binary  = 1'b0;
    is_unary   = 1'b0;
    is_muldiv  = 1'b0;
    is_halt    = 1'b0;
    is_illegal = 1'b0;
    case (opcode)
      OpAnd, OpOr, OpShl, OpShr, OpRor, OpRol, OpAdd, OpSub: is_binary = 1'b1;
      OpNeg, OpNot:                                           is_unary  = 1'b1;
      OpMul, OpDiv:                                           is_muldiv = 1'b1;
      OpHalt:                                                 is_halt   = 1'b1;
      default:                                                is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/ctrl_sequencer.sv
// Hardwired fetch/decode/execute control sequencer (Moore outputs).
// Optional performance counters are enabled with `define CTRL_SEQ_PERF_CNT_EN.
module ctrl_sequencer
  import ctrl_seq_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  ctrl_seq_if.master  ctl
`ifdef CTRL_SEQ_PERF_CNT_EN
  ,
  output logic [31:0] instr_count,
  output logic [31:0] stall_count
`endif
);

  state_e state_q, state_d;

  logic [OPCODE_W-1:0]  opcode;
  logic [REG_SEL_W-1:0] ra, rb, rc;
  logic                 is_binary, is_unary, is_muldiv, is_halt, is_illegal;
  logic                 unused_ir;

  assign opcode    = ctl.ir[IrOpMsb:IrOpLsb];
  assign ra        = ctl.ir[IrRaMsb:IrRaLsb];
  assign rb        = ctl.ir[IrRbMsb:IrRbLsb];
  assign rc        = ctl.ir[IrRcMsb:IrRcLsb];
  assign unused_ir = ^ctl.ir[IrRcLsb-1:0];

  instr_decode u_decode (
    .opcode     (opcode),
    .is_binary  (is_binary),
    .is_unary   (is_unary),
    .is_muldiv  (is_muldiv),
    .is_halt    (is_halt),
    .is_illegal (is_illegal)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d         = state_q;
    ctl.pc_out      = 1'b0;
    ctl.zlow_out    = 1'b0;
    ctl.zhigh_out   = 1'b0;
    ctl.mdr_out     = 1'b0;
    ctl.reg_out_en  = 1'b0;
    ctl.reg_out_sel = '0;
    ctl.pc_in       = 1'b0;
    ctl.mar_in      = 1'b0;
    ctl.mdr_in      = 1'b0;
    ctl.ir_in       = 1'b0;
    ctl.y_in        = 1'b0;
    ctl.z_in        = 1'b0;
    ctl.hi_in       = 1'b0;
    ctl.lo_in       = 1'b0;
    ctl.reg_in_en   = 1'b0;
    ctl.reg_in_sel  = '0;
    ctl.inc_pc      = 1'b0;
    ctl.mem_read    = 1'b0;
    ctl.alu_ctrl    = '0;
    ctl.instr_done  = 1'b0;
    ctl.illegal_op  = 1'b0;
    ctl.halted      = 1'b0;

    unique case (state_q)
      StIdle: if (ctl.run) state_d = StT0;
      StT0: begin
        ctl.pc_out = 1'b1;
        ctl.mar_in = 1'b1;
        ctl.inc_pc = 1'b1;
        ctl.z_in   = 1'b1;
        state_d    = StT1;
      end
      StT1: begin
        ctl.zlow_out = 1'b1;
        ctl.pc_in    = 1'b1;
        ctl.mem_read = 1'b1;
        ctl.mdr_in   = 1'b1;
        state_d      = StMemw;
      end
      // Always at least one wait cycle, even if memory was already ready in T1.
      StMemw: begin
        ctl.mem_read = 1'b1;
        ctl.mdr_in   = 1'b1;
        if (ctl.mem_ready) state_d = StT2;
      end
      StT2: begin
        ctl.mdr_out = 1'b1;
        ctl.ir_in   = 1'b1;
        state_d     = StDec;
      end
      StDec: begin
        if (is_illegal) begin
          ctl.illegal_op = 1'b1;
          ctl.instr_done = 1'b1;
          state_d        = ctl.run ? StT0 : StIdle;
        end else if (is_halt) begin
          state_d = StHalt;
        end else begin
          state_d = StT3;
        end
      end
      StT3: begin
        ctl.reg_out_en  = 1'b1;
        ctl.reg_out_sel = rb;
        ctl.y_in        = 1'b1;
        state_d         = StT4;
      end
      StT4: begin
        ctl.reg_out_en  = 1'b1;
        ctl.reg_out_sel = is_unary ? rb : rc;
        ctl.z_in        = 1'b1;
        ctl.alu_ctrl    = alu_code(opcode);
        state_d         = StT5;
      end
      StT5: begin
        ctl.zlow_out = 1'b1;
        if (is_muldiv) begin
          ctl.lo_in = 1'b1;
          state_d   = StT6;
        end else begin
          ctl.reg_in_en  = 1'b1;
          ctl.reg_in_sel = ra;
          ctl.instr_done = 1'b1;
          state_d        = ctl.run ? StT0 : StIdle;
        end
      end
      StT6: begin
        ctl.zhigh_out  = 1'b1;
        ctl.hi_in      = 1'b1;
        ctl.instr_done = 1'b1;
        state_d        = ctl.run ? StT0 : StIdle;
      end
      StHalt:  ctl.halted = 1'b1;
      default: state_d = StIdle;
    endcase
  end

`ifdef CTRL_SEQ_PERF_CNT_EN
  logic [31:0] instr_count_q, stall_count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      instr_count_q <= '0;
      stall_count_q <= '0;
    end else begin
      if (ctl.instr_done) instr_count_q <= instr_count_q + 32'd1;
      if (state_q == StMemw && !ctl.mem_ready) stall_count_q <= stall_count_q + 32'd1;
    end
  end

  assign instr_count = instr_count_q;
  assign stall_count = stall_count_q;
`endif

  // is_binary is implied by the absence of the other classes in the state logic.
  logic unused_class;
  assign unused_class = is_binary;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Self-checking bench: per-cycle expected control vectors queued as stimulus is driven.
module tb_ctrl_sequencer;
  import ctrl_seq_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ctrl_seq_if ctl_if ();

  ctrl_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .ctl   (ctl_if)
  );

  typedef struct packed {
    logic       pc_out, zlow_out, zhigh_out, mdr_out, reg_out_en;
    logic [3:0] reg_out_sel;
    logic       pc_in, mar_in, mdr_in, ir_in, y_in, z_in, hi_in, lo_in, reg_in_en;
    logic [3:0] reg_in_sel;
    logic       inc_pc, mem_read;
    logic [3:0] alu_ctrl;
    logic       instr_done, illegal_op, halted;
  } ctl_t;

  typedef struct packed {
    logic        rst;
    logic        run;
    logic        rdy;
    logic [31:0] ir;
    ctl_t        exp;
  } stim_t;

  localparam logic [1:0] KBin = 2'd0, KUn = 2'd1, KMd = 2'd2, KIll = 2'd3;

  typedef struct packed {
    logic [4:0] op;
    logic [3:0] ra, rb, rc;
    logic [1:0] waits;
    logic       rdy_t1;
    logic       run;
    logic [1:0] kind;
  } vec_t;

  stim_t stim_q[$];
  string name_q[$];
  ctl_t  exp_q[$];
  string exp_name_q[$];
  int    lat_q[$];
  int    checks = 0;
  int    failures = 0;
  int    cyc = 0;
  int    t0_cyc = 0;
  vec_t  vecs[10];

  function automatic ctl_t c_t0();
    ctl_t c = '0;
    c.pc_out = 1; c.mar_in = 1; c.inc_pc = 1; c.z_in = 1;
    return c;
  endfunction
  function automatic ctl_t c_t1();
    ctl_t c = '0;
    c.zlow_out = 1; c.pc_in = 1; c.mem_read = 1; c.mdr_in = 1;
    return c;
  endfunction
  function automatic ctl_t c_memw();
    ctl_t c = '0;
    c.mem_read = 1; c.mdr_in = 1;
    return c;
  endfunction
  function automatic ctl_t c_t2();
    ctl_t c = '0;
    c.mdr_out = 1; c.ir_in = 1;
    return c;
  endfunction
  function automatic ctl_t c_ill();
    ctl_t c = '0;
    c.illegal_op = 1; c.instr_done = 1;
    return c;
  endfunction
  function automatic ctl_t c_t3(logic [3:0] sel);
    ctl_t c = '0;
    c.reg_out_en = 1; c.reg_out_sel = sel; c.y_in = 1;
    return c;
  endfunction
  function automatic ctl_t c_t4(logic [3:0] sel, logic [3:0] alu);
    ctl_t c = '0;
    c.reg_out_en = 1; c.reg_out_sel = sel; c.z_in = 1; c.alu_ctrl = alu;
    return c;
  endfunction
  function automatic ctl_t c_t5wb(logic [3:0] ra);
    ctl_t c = '0;
    c.zlow_out = 1; c.reg_in_en = 1; c.reg_in_sel = ra; c.instr_done = 1;
    return c;
  endfunction
  function automatic ctl_t c_t5lo();
    ctl_t c = '0;
    c.zlow_out = 1; c.lo_in = 1;
    return c;
  endfunction
  function automatic ctl_t c_t6();
    ctl_t c = '0;
    c.zhigh_out = 1; c.hi_in = 1; c.instr_done = 1;
    return c;
  endfunction
  function automatic ctl_t c_halt();
    ctl_t c = '0;
    c.halted = 1;
    return c;
  endfunction

  function automatic ctl_t sample();
    ctl_t c;
    c.pc_out = ctl_if.pc_out;         c.zlow_out = ctl_if.zlow_out;
    c.zhigh_out = ctl_if.zhigh_out;   c.mdr_out = ctl_if.mdr_out;
    c.reg_out_en = ctl_if.reg_out_en; c.reg_out_sel = ctl_if.reg_out_sel;
    c.pc_in = ctl_if.pc_in;           c.mar_in = ctl_if.mar_in;
    c.mdr_in = ctl_if.mdr_in;         c.ir_in = ctl_if.ir_in;
    c.y_in = ctl_if.y_in;             c.z_in = ctl_if.z_in;
    c.hi_in = ctl_if.hi_in;           c.lo_in = ctl_if.lo_in;
    c.reg_in_en = ctl_if.reg_in_en;   c.reg_in_sel = ctl_if.reg_in_sel;
    c.inc_pc = ctl_if.inc_pc;         c.mem_read = ctl_if.mem_read;
    c.alu_ctrl = ctl_if.alu_ctrl;     c.instr_done = ctl_if.instr_done;
    c.illegal_op = ctl_if.illegal_op; c.halted = ctl_if.halted;
    return c;
  endfunction

  task automatic push(input logic rs, input logic rn, input logic rdy, input logic [31:0] ir,
                      input ctl_t e, input string nm);
    stim_t s;
    s.rst = rs; s.run = rn; s.rdy = rdy; s.ir = ir; s.exp = e;
    stim_q.push_back(s);
    name_q.push_back(nm);
  endtask

  // Fetch part shared by every instruction; leaves the DUT in DEC on the last pushed cycle.
  task automatic push_fetch(input logic [31:0] ir, input logic rn, input int waits,
                            input logic rdy_t1);
    push(0, rn, 0, ir, c_t0(), "t0");
    push(0, rn, rdy_t1, ir, c_t1(), "t1");
    for (int i = 0; i < waits; i++) push(0, rn, 0, ir, c_memw(), "memw_wait");
    push(0, rn, 1, ir, c_memw(), "memw");
    push(0, rn, 0, ir, c_t2(), "t2");
  endtask

  task automatic build_instr(input vec_t v);
    logic [31:0] ir;
    ir = {v.op, v.ra, v.rb, v.rc, 15'h0};
    push_fetch(ir, v.run, int'(v.waits), v.rdy_t1);
    if (v.kind == KIll) begin
      push(0, v.run, 0, ir, c_ill(), "dec_illegal");
      lat_q.push_back(4 + int'(v.waits));
    end else begin
      push(0, v.run, 0, ir, '0, "dec");
      push(0, v.run, 0, ir, c_t3(v.rb), "t3");
      push(0, v.run, 0, ir, c_t4((v.kind == KUn) ? v.rb : v.rc, v.op[3:0]), "t4");
      if (v.kind == KMd) begin
        push(0, v.run, 0, ir, c_t5lo(), "t5_lo");
        push(0, v.run, 0, ir, c_t6(), "t6");
        lat_q.push_back(8 + int'(v.waits));
      end else begin
        push(0, v.run, 0, ir, c_t5wb(v.ra), "t5_wb");
        lat_q.push_back(7 + int'(v.waits));
      end
    end
    if (!v.run) push(0, 1, 0, ir, '0, "idle_after_run_drop");
  endtask

  task automatic run_all();
    stim_t s;
    ctl_t  act, e;
    string nm;
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      nm = name_q.pop_front();
      @(posedge clk);
      #1;
      reset = s.rst;
      ctl_if.run = s.run;
      ctl_if.mem_ready = s.rdy;
      ctl_if.ir = s.ir;
      exp_q.push_back(s.exp);
      exp_name_q.push_back(nm);
      @(negedge clk);
      cyc++;
      act = sample();
      e = exp_q.pop_front();
      nm = exp_name_q.pop_front();
      checks++;
      if (act !== e) begin
        failures++;
        $display("FAIL %s ir=%h got=%h want=%h", nm, s.ir, act, e);
      end
      checks++;
      if (!$onehot0({act.pc_out, act.zlow_out, act.zhigh_out, act.mdr_out, act.reg_out_en})) begin
        failures++;
        $display("FAIL bus_onehot0 step=%s got=%b want=onehot0", nm,
                 {act.pc_out, act.zlow_out, act.zhigh_out, act.mdr_out, act.reg_out_en});
      end
      if (act.pc_out && act.mar_in) t0_cyc = cyc;
      if (act.instr_done && lat_q.size() > 0) begin
        int want;
        want = lat_q.pop_front();
        checks++;
        if (cyc - t0_cyc != want) begin
          failures++;
          $display("FAIL latency ir=%h got=%0d want=%0d", s.ir, cyc - t0_cyc, want);
        end
      end
    end
  endtask

  initial begin
    logic [31:0] ir;
    ctl_if.run = 1'b0;
    ctl_if.mem_ready = 1'b0;
    ctl_if.ir = '0;

    vecs[0] = '{5'b01001, 4'd5,  4'd2,  4'd4,  2'd0, 1'b0, 1'b1, KBin};  // SUB R5,R2,R4
    vecs[1] = '{5'b01010, 4'd0,  4'd3,  4'd6,  2'd0, 1'b0, 1'b1, KMd};   // MUL R3,R6
    vecs[2] = '{5'b01000, 4'd7,  4'd1,  4'd9,  2'd3, 1'b0, 1'b1, KBin};  // ADD, 3 waits
    vecs[3] = '{5'b00011, 4'd0,  4'd0,  4'd0,  2'd0, 1'b0, 1'b1, KIll};  // 0x18000000
    vecs[4] = '{5'b01100, 4'd1,  4'd7,  4'd0,  2'd0, 1'b1, 1'b1, KUn};   // NEG, ready in T1
    vecs[5] = '{5'b01101, 4'd15, 4'd14, 4'd13, 2'd0, 1'b0, 1'b0, KUn};   // NOT, run dropped
    vecs[6] = '{5'b01011, 4'd2,  4'd9,  4'd11, 2'd1, 1'b0, 1'b1, KMd};   // DIV, 1 wait
    vecs[7] = '{5'b00001, 4'd15, 4'd14, 4'd13, 2'd0, 1'b0, 1'b1, KBin};  // AND
    vecs[8] = '{5'b00111, 4'd3,  4'd4,  4'd5,  2'd2, 1'b1, 1'b1, KBin};  // ROL
    vecs[9] = '{5'b10000, 4'd1,  4'd2,  4'd3,  2'd0, 1'b0, 1'b0, KIll};  // illegal, run dropped

    push(1, 0, 0, 32'h0, '0, "reset_idle");
    push(0, 1, 0, 32'h0, '0, "idle_run");
    for (int i = 0; i < 10; i++) build_instr(vecs[i]);

    // Reset during T4 aborts: no write-back, back to IDLE.
    ir = 32'h4A92_0000;
    push_fetch(ir, 1, 0, 0);
    push(0, 1, 0, ir, '0, "dec");
    push(0, 1, 0, ir, c_t3(4'd2), "t3");
    push(1, 1, 0, ir, c_t4(4'd4, 4'd9), "t4_reset");
    push(0, 0, 0, ir, '0, "idle_after_reset");
    push(0, 1, 0, ir, '0, "idle_rerun");

    // HALT holds with run high until reset.
    ir = 32'hF800_0000;
    push_fetch(ir, 1, 0, 0);
    push(0, 1, 0, ir, '0, "dec_halt");
    for (int i = 0; i < 20; i++) push(0, 1, 0, ir, c_halt(), "halted");
    push(1, 1, 0, ir, c_halt(), "halted_reset");
    push(0, 0, 0, ir, '0, "idle_after_halt");
    push(0, 0, 0, ir, '0, "idle_stay");

    run_all();

    checks++;
    if (lat_q.size() != 0) begin
      failures++;
      $display("FAIL missing_instr_done got=%0d want=0 outstanding", lat_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ctrl_sequencer.md
Name: ctrl_sequencer

Overview:
- Hardwired control unit that drives the datapath's strobe-style control inputs. It replaces the per-step signal driving currently done by hand.
- Runs the instruction fetch sequence T0–T2, including a memory-ready wait. Then decodes IR and runs the execute steps for register ALU, MUL/DIV, unary and HALT instructions.
- Sits beside the datapath. It owns every register-enable, bus-source select, ALU control and memory-read strobe.

Parameters:
- WORD_W, 32, IR / data word width
- REG_SEL_W, 4, GPR index width (R0–R15)
- ALU_CTRL_W, 4, ALU control code width

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- run  in  1  level; allows a new fetch
- ir  in  WORD_W  current IR contents
- mem_ready  in  1  memory read data valid on Mdata_in this cycle
- pc_out, zlow_out, zhigh_out, mdr_out  out  1  bus-source enables
- reg_out_en  out  1  GPR drives the bus
- reg_out_sel  out  REG_SEL_W  which GPR drives the bus
- pc_in, mar_in, mdr_in, ir_in, y_in, z_in, hi_in, lo_in  out  1  register load enables
- reg_in_en  out  1  GPR load enable
- reg_in_sel  out  REG_SEL_W  which GPR is loaded
- inc_pc  out  1  ALU PC-increment mode
- mem_read  out  1  MDR source = memory
- alu_ctrl  out  ALU_CTRL_W  ALU operation code
- instr_done  out  1  one-cycle pulse on the last execute step
- illegal_op  out  1  one-cycle pulse on an undefined opcode
- halted  out  1  level; HALT reached

Behaviour:
- IR fields: opcode = ir[31:27], ra = ir[26:23], rb = ir[22:19], rc = ir[18:15].
- Opcodes; alu_ctrl = opcode[3:0]:
  - AND 00001, OR 00010, SHL 00100, SHR 00101, ROR 00110, ROL 00111
  - ADD 01000, SUB 01001, MUL 01010, DIV 01011, NEG 01100, NOT 01101
  - HALT 11111; all others are illegal.
- Outputs are combinational from the state register and the IR fields (Moore). Every control not listed for a state is 0.
- Reset (synchronous): state = IDLE; all outputs 0; halted = 0. Reset at any step, including MEMW, aborts the instruction with no further strobes.
- IDLE: all controls 0; go to T0 when run = 1.
- T0: pc_out, mar_in, inc_pc, z_in.
- T1: zlow_out, pc_in, mem_read, mdr_in; then MEMW.
- MEMW: mem_read, mdr_in held.
  - mem_ready = 1: go to T2.
  - Otherwise stay, with no timeout.
  - mem_ready already high during T1 still passes through exactly one MEMW cycle.
- T2: mdr_out, ir_in; then DEC.
- DEC: no strobes; classifies the IR sampled this cycle.
  - ALU/MUL/DIV/unary: go to T3.
  - HALT: go to HALT.
  - Illegal: illegal_op = 1 and instr_done = 1; go to T0 if run, else IDLE.
- T3: reg_out_en, reg_out_sel = rb, y_in.
- T4: reg_out_en, z_in, alu_ctrl = opcode[3:0]. reg_out_sel = rc for binary ops, rb for NEG/NOT.
- T5:
  - Binary/unary ops: zlow_out, reg_in_en, reg_in_sel = ra, instr_done.
  - MUL/DIV: zlow_out, lo_in; then T6.
- T6 (MUL/DIV only): zhigh_out, hi_in, instr_done. ra is ignored for MUL/DIV.
- After the instr_done step: go to T0 if run = 1, else IDLE. Dropping run mid-instruction finishes the current instruction.
- HALT: halted = 1, all controls 0; exits only via reset.
- Latency, fetch to done: 7 cycles for register ALU/unary, 8 for MUL/DIV, assuming mem_ready in the first MEMW cycle. Add N for N extra wait cycles.
- At most one bus source is asserted per cycle. Formal/bench assertion: onehot0 of {pc_out, zlow_out, zhigh_out, mdr_out, reg_out_en}.

Optional Feature:
- Macro CTRL_SEQ_PERF_CNT_EN.
- Defined: adds output instr_count (32 bits) and output stall_count (32 bits).
  - instr_count increments on each instr_done; stall_count increments on each MEMW cycle with mem_ready = 0.
  - Both clear on reset and wrap modulo 2^32.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Decomposition:
- ctrl_seq_pkg holds:
  - state enum: IDLE, T0, T1, MEMW, T2, DEC, T3, T4, T5, T6, HALT
  - opcode constants
  - ALU control code constants
  - IR field bit positions
- One sub-module, instr_decode (combinational): opcode → is_binary, is_unary, is_muldiv, is_halt, is_illegal.

Test Plan:
- run = 1, ir = 0x4A920000 (SUB R5,R2,R4), mem_ready in the first MEMW cycle:
  - T3: reg_out_sel = 2 with y_in.
  - T4: reg_out_sel = 4, alu_ctrl = 9, z_in.
  - T5: reg_in_sel = 5, instr_done.
  - Total 7 cycles; then T0.
- ir = 0x501B0000 (MUL R3,R6): T4 reg_out_sel = 6, alu_ctrl = 10; T5 lo_in; T6 hi_in; instr_done in T6 only.
- mem_ready held low 3 cycles: mem_read/mdr_in stay high for 4 MEMW cycles; ir_in pulses exactly once.
- ir = 0x18000000 (opcode 00011): illegal_op and instr_done pulse in DEC; no y_in, z_in or reg_in_en.
- ir = 0xF8000000: halted = 1 and stays with run = 1 for 20 cycles; reset returns to IDLE with halted = 0.
- reset asserted during T4: next cycle state IDLE, all outputs 0; no reg_in_en ever issued.
